// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding read to instruction memory, result latched into the IR.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-cycle timeout with a sticky fetch_err and an ERR state.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no read outstanding; accepts fetch_req
// S_WAIT | read outstanding, mem_rd held until mem_ready or flush
// S_ERR  | read timed out (FETCH_TIMEOUT_EN only); accepts fetch_req or flush
module instr_fetch #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               fetch_req,
  input  logic               flush,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic [4:0]         opcode,
  output logic [7:0]         offset_addr,
  output logic               fetch_busy,
  output logic               fetch_err
);

  if (INSTR_W < 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("instr_fetch: INSTR_W must be >= 16 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic                busy_q, busy_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                err_q, err_d;

  assign cnt_inc = cnt_q + CNT_W'(1);
`endif

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    busy_d     = busy_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE, S_ERR: begin
        // flush beats fetch_req; in ERR it returns to IDLE leaving fetch_err set
        if (flush) begin
          state_d = S_IDLE;
        end else if (fetch_req) begin
          state_d    = S_WAIT;
          mem_addr_d = pc_in;
          mem_rd_d   = 1'b1;
          busy_d     = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt_d      = '0;
          err_d      = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d  = S_IDLE;
          mem_rd_d = 1'b0;
          busy_d   = 1'b0;
        end else if (mem_ready) begin
          state_d    = S_IDLE;
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
          busy_d     = 1'b0;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          // the TIMEOUT_CYC-th WAIT cycle without ready ends the fetch
          if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
            state_d  = S_ERR;
            mem_rd_d = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b1;
          end
          cnt_d = cnt_inc;
`endif
        end
      end
      default: begin
        state_d  = S_IDLE;
        mem_rd_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign ir_out      = ir_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_busy  = busy_q;
  assign opcode      = ir_q[INSTR_W-1 -: 5];
  assign offset_addr = ir_q[7:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle table for the main handshake cases plus
// hand-written reset, long-wait and (with FETCH_TIMEOUT_EN) timeout sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_in = '0;
  logic        fetch_req = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic [4:0]  opcode;
  logic [7:0]  offset_addr;
  logic        fetch_busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16), .INSTR_W(16), .TIMEOUT_CYC(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .fetch_req   (fetch_req),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .opcode      (opcode),
    .offset_addr (offset_addr),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    logic        req;
    logic        fl;
    logic        rdy;
    logic [15:0] rdata;
    logic [15:0] pc;
    logic        e_rd;
    logic [15:0] e_addr;
    logic [15:0] e_ir;
    logic        e_valid;
    logic        e_busy;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic req, input logic fl, input logic rdy,
                              input logic [15:0] rdata, input logic [15:0] pc,
                              input logic e_rd, input logic [15:0] e_addr,
                              input logic [15:0] e_ir, input logic e_valid,
                              input logic e_busy);
    vec_t v;
    v.req = req; v.fl = fl; v.rdy = rdy; v.rdata = rdata; v.pc = pc;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_ir = e_ir;
    v.e_valid = e_valid; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // inputs change at the falling edge; outputs are sampled at the next falling edge
  task automatic step(input logic req, input logic fl, input logic rdy,
                      input logic [15:0] rdata, input logic [15:0] pc);
    fetch_req = req;
    flush     = fl;
    mem_ready = rdy;
    mem_rdata = rdata;
    pc_in     = pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic e_rd, input logic [15:0] e_addr,
                         input logic [15:0] e_ir, input logic e_valid, input logic e_busy,
                         input logic e_err);
    logic [15:0] eir;
    eir = e_ir;
    chk({tag, ".mem_rd"},      mem_rd,      e_rd);
    chk({tag, ".mem_addr"},    mem_addr,    e_addr);
    chk({tag, ".ir_out"},      ir_out,      eir);
    chk({tag, ".ir_valid"},    ir_valid,    e_valid);
    chk({tag, ".fetch_busy"},  fetch_busy,  e_busy);
    chk({tag, ".fetch_err"},   fetch_err,   e_err);
    chk({tag, ".opcode"},      opcode,      eir[15:11]);
    chk({tag, ".offset_addr"}, offset_addr, eir[7:0]);
  endtask

  initial begin
    //            req   fl    rdy   rdata     pc          rd    addr      ir        vld   busy
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0010,   1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 16'hA5C3, 16'h0000,   1'b0, 16'h0010, 16'hA5C3, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0020,   1'b1, 16'h0020, 16'hA5C3, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000,   1'b0, 16'h0020, 16'hA5C3, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0030,   1'b0, 16'h0020, 16'hA5C3, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0000,   1'b0, 16'h0020, 16'hA5C3, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0123,   1'b1, 16'h0123, 16'hA5C3, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 16'hDEAD, 16'h0999,   1'b1, 16'h0123, 16'hA5C3, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 16'hDEAD, 16'h0000,   1'b1, 16'h0123, 16'hA5C3, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0555,   1'b1, 16'h0123, 16'hA5C3, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000,   1'b1, 16'h0123, 16'hA5C3, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000,   1'b0, 16'h0123, 16'h1234, 1'b1, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000,   1'b1, 16'h0000, 16'h1234, 1'b0, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 16'h1111, 16'h0001,   1'b0, 16'h0000, 16'h1111, 1'b1, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001,   1'b1, 16'h0001, 16'h1111, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 1'b0, 1'b1, 16'h2222, 16'h0002,   1'b0, 16'h0001, 16'h2222, 1'b1, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002,   1'b1, 16'h0002, 16'h2222, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 16'h3333, 16'h0000,   1'b0, 16'h0002, 16'h3333, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000,   1'b0, 16'h0002, 16'h3333, 1'b0, 1'b0);

    // reset state
    #12;
    chk_all("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].req, vecs[i].fl, vecs[i].rdy, vecs[i].rdata, vecs[i].pc);
      chk_all($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_ir,
              vecs[i].e_valid, vecs[i].e_busy, 1'b0);
    end

    // asynchronous reset in the middle of a wait
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0077);
    chk_all("rst_pre", 1'b1, 16'h0077, 16'h3333, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000);
    chk_all("rst_idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005);
    chk_all("rst_req", 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'hABCD, 16'h0000);
    chk_all("rst_done", 1'b0, 16'h0005, 16'hABCD, 1'b1, 1'b0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    // 15 WAIT cycles without ready end in ERR
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0040);
    for (int k = 1; k < 15; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk_all($sformatf("to_wait%0d", k), 1'b1, 16'h0040, 16'hABCD, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk_all("to_err", 1'b0, 16'h0040, 16'hABCD, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk_all("to_flush", 1'b0, 16'h0040, 16'hABCD, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0041);
    chk_all("to_clear", 1'b1, 16'h0041, 16'hABCD, 1'b0, 1'b1, 1'b0);
    // ready arriving in the timeout cycle wins
    for (int k = 1; k < 15; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    chk_all("to_w14", 1'b1, 16'h0041, 16'hABCD, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h7E01, 16'h0000);
    chk_all("to_ready", 1'b0, 16'h0041, 16'h7E01, 1'b1, 1'b0, 1'b0);
`else
    // without the timeout, WAIT persists and fetch_err stays low
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0040);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk_all($sformatf("long_wait%0d", k), 1'b1, 16'h0040, 16'hABCD, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk_all("long_flush", 1'b0, 16'h0040, 16'hABCD, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
